// File: rtl/updown_counter_pkg.sv
// Shared constants and parameter legality check for the parametrised up/down counter.
// Imported by the counter top level and its next-value logic.
package updown_counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // True when the range, step, reset value and mode form a usable counter.
    function automatic bit params_ok(
        input int width,
        input int min_val,
        input int max_val,
        input int step,
        input int saturate,
        input int reset_val
    );
        bit ok;
        ok = (width >= 1) && (width <= 30);
        ok = ok && (min_val >= 0) && (min_val < max_val);
        ok = ok && (max_val <= (1 << width) - 1);
        ok = ok && (step >= 1) && (step <= max_val - min_val);
        ok = ok && (saturate == CNT_WRAP || saturate == CNT_SAT);
        ok = ok && (reset_val >= min_val) && (reset_val <= max_val);
        return ok;
    endfunction

endpackage

// File: rtl/updown_next_val.sv
// Combinational next-count logic: load clamping, step arithmetic one bit wider than the
// count, and bound-crossing detection in either wrap or saturate mode.
module updown_next_val
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int STEP     = 1,
    parameter int SATURATE = CNT_WRAP
)(
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_next,
    output logic             o_evt
);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_load_x;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_diff;
    logic             w_up_cross;
    logic             w_dn_cross;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_cnt_x   = {1'b0, i_count};
    assign w_load_x  = {1'b0, i_load_val};
    assign w_up_sum  = w_cnt_x + STEP_X;
    assign w_dn_diff = w_cnt_x - STEP_X;

    // Down crossing tested as count < MIN+STEP so the subtraction never has to go negative.
    assign w_up_cross = (w_up_sum > MAX_X);
    assign w_dn_cross = (w_cnt_x < (MIN_X + STEP_X));

    always_comb begin
        w_load_clamped = i_load_val;
        if (w_load_x > MAX_X) begin
            w_load_clamped = MAX_W;
        end else if (w_load_x < MIN_X) begin
            w_load_clamped = MIN_W;
        end
    end

    always_comb begin
        o_next = i_count;
        o_evt  = 1'b0;
        if (i_load) begin
            o_next = w_load_clamped;
        end else if (i_up) begin
            if (w_up_cross) begin
                o_evt  = 1'b1;
                o_next = (SATURATE == CNT_SAT) ? MAX_W : MIN_W;
            end else begin
                o_next = w_up_sum[WIDTH-1:0];
            end
        end else if (i_down) begin
            if (w_dn_cross) begin
                o_evt  = 1'b1;
                o_next = (SATURATE == CNT_SAT) ? MIN_W : MAX_W;
            end else begin
                o_next = w_dn_diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, limit flags, one-cycle bound event and sticky overflow.
// All outputs come straight from registers; next-value arithmetic lives in updown_next_val.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int STEP      = 1,
    parameter int SATURATE  = CNT_WRAP,
    parameter int RESET_VAL = MIN_VAL
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_en,
    input  logic             down_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_evt,
    output logic             overflow
);

    if (!params_ok(WIDTH, MIN_VAL, MAX_VAL, STEP, SATURATE, RESET_VAL)) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/MIN_VAL/MAX_VAL/STEP/SATURATE/RESET_VAL");
    end

    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_wrap_evt;
    logic             r_overflow;

    logic [WIDTH-1:0] w_next;
    logic             w_evt;
    logic             w_up;
    logic             w_down;

    // Up has priority when both directions are requested.
    assign w_up   = enable & up_en;
    assign w_down = enable & down_en & ~up_en;

    updown_next_val #(
        .WIDTH    (WIDTH),
        .MIN_VAL  (MIN_VAL),
        .MAX_VAL  (MAX_VAL),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next_val (
        .i_count    (r_count),
        .i_up       (w_up),
        .i_down     (w_down),
        .i_load     (load),
        .i_load_val (load_val),
        .o_next     (w_next),
        .o_evt      (w_evt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= RESET_W;
            r_at_max   <= (RESET_W == MAX_W);
            r_at_min   <= (RESET_W == MIN_W);
            r_wrap_evt <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_at_max   <= (w_next == MAX_W);
            r_at_min   <= (w_next == MIN_W);
            r_wrap_evt <= w_evt;
            // A new event beats a simultaneous clear.
            if (w_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign at_max   = r_at_max;
    assign at_min   = r_at_min;
    assign wrap_evt = r_wrap_evt;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus stream
// (default wrap 0..15, saturate 2..10 step 3, wrap 0..9) against an integer reference model.
module tb_updown_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_en = 1'b0;
  logic       down_en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       clr_flags = 1'b0;

  logic [3:0] o_cnt [3];
  logic       o_max [3];
  logic       o_min [3];
  logic       o_evt [3];
  logic       o_ovf [3];

  int cfg_min  [3] = '{0, 2, 0};
  int cfg_max  [3] = '{15, 10, 9};
  int cfg_step [3] = '{1, 3, 1};
  int cfg_sat  [3] = '{0, 1, 0};

  int m_cnt [3];
  int m_ovf [3];
  int m_evt [3];

  int n_vec = 0;
  int n_err = 0;

  updown_counter_param u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(o_cnt[0]), .at_max(o_max[0]), .at_min(o_min[0]), .wrap_evt(o_evt[0]), .overflow(o_ovf[0])
  );

  updown_counter_param #(
    .WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .STEP(3), .SATURATE(1), .RESET_VAL(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(o_cnt[1]), .at_max(o_max[1]), .at_min(o_min[1]), .wrap_evt(o_evt[1]), .overflow(o_ovf[1])
  );

  updown_counter_param #(
    .WIDTH(4), .MAX_VAL(9)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(o_cnt[2]), .at_max(o_max[2]), .at_min(o_min[2]), .wrap_evt(o_evt[2]), .overflow(o_ovf[2])
  );

  // Packed as {count, at_max, at_min, wrap_evt, overflow}.
  function automatic logic [7:0] obs_vec(input int k);
    return {o_cnt[k], o_max[k], o_min[k], o_evt[k], o_ovf[k]};
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    logic [3:0] c;
    c = 4'(m_cnt[k]);
    return {c, (m_cnt[k] == cfg_max[k]), (m_cnt[k] == cfg_min[k]), (m_evt[k] != 0), (m_ovf[k] != 0)};
  endfunction

  // Reference: what one clock edge does to each configuration, in plain integer terms.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int lv;
      lv = int'(load_val);
      m_evt[k] = 0;
      if (reset) begin
        m_cnt[k] = cfg_min[k];
        m_ovf[k] = 0;
      end else begin
        if (load) begin
          m_cnt[k] = (lv > cfg_max[k]) ? cfg_max[k] : (lv < cfg_min[k]) ? cfg_min[k] : lv;
        end else if (enable && up_en) begin
          if (m_cnt[k] + cfg_step[k] > cfg_max[k]) begin
            m_evt[k] = 1;
            m_cnt[k] = cfg_sat[k] ? cfg_max[k] : cfg_min[k];
          end else begin
            m_cnt[k] = m_cnt[k] + cfg_step[k];
          end
        end else if (enable && down_en) begin
          if (m_cnt[k] - cfg_step[k] < cfg_min[k]) begin
            m_evt[k] = 1;
            m_cnt[k] = cfg_sat[k] ? cfg_min[k] : cfg_max[k];
          end else begin
            m_cnt[k] = m_cnt[k] - cfg_step[k];
          end
        end
        if (m_evt[k] != 0) m_ovf[k] = 1;
        else if (clr_flags) m_ovf[k] = 0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [3:0] lv,
                       input logic en, input logic up, input logic dn, input logic clr);
    @(negedge clk);
    reset = rst; load = ld; load_val = lv; enable = en; up_en = up; down_en = dn; clr_flags = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL reset dut%0d: got %b required %b", k, obs_vec(k), exp_vec(k));
      end
    end
    n_vec++;
    if (obs_vec(0) !== 8'b0000_0100) begin
      n_err++;
      $display("FAIL reset_const dut0: got %b required %b", obs_vec(0), 8'b0000_0100);
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL count_up dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_vec++;
    if (o_cnt[0] !== 4'd5) begin
      n_err++;
      $display("FAIL count_up_const dut0: got %0d required 5", o_cnt[0]);
    end
  endtask

  task automatic test_wrap();
    logic ld_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic up_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   c_t  [4] = '{14, 15, 0, 0};
    int   e_t  [4] = '{0, 0, 1, 0};
    int   v_t  [4] = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ld_t[i], 4'd14, 1'b1, up_t[i], 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL wrap dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (int'(o_cnt[0]) != c_t[i] || int'(o_evt[0]) != e_t[i] || int'(o_ovf[0]) != v_t[i]) begin
        n_err++;
        $display("FAIL wrap_const dut0 step%0d: got cnt=%0d evt=%0d ovf=%0d required cnt=%0d evt=%0d ovf=%0d",
                 i, o_cnt[0], o_evt[0], o_ovf[0], c_t[i], e_t[i], v_t[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic ld_t [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic up_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic dn_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   c_t  [6] = '{9, 10, 10, 7, 4, 2};
    int   e_t  [6] = '{0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, ld_t[i], 4'd9, 1'b1, up_t[i], dn_t[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL saturate dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (int'(o_cnt[1]) != c_t[i] || int'(o_evt[1]) != e_t[i]) begin
        n_err++;
        $display("FAIL saturate_const dut1 step%0d: got cnt=%0d evt=%0d required cnt=%0d evt=%0d",
                 i, o_cnt[1], o_evt[1], c_t[i], e_t[i]);
      end
    end
  endtask

  task automatic test_both_dirs();
    logic ld_t [3] = '{1'b1, 1'b0, 1'b0};
    logic en_t [3] = '{1'b0, 1'b1, 1'b0};
    logic dn_t [3] = '{1'b0, 1'b1, 1'b0};
    int   c_t  [3] = '{5, 6, 6};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ld_t[i], 4'd5, en_t[i], 1'b1, dn_t[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL both_dirs dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (int'(o_cnt[0]) != c_t[i]) begin
        n_err++;
        $display("FAIL both_dirs_const dut0 step%0d: got %0d required %0d", i, o_cnt[0], c_t[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    logic ld_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic en_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic clr_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   c_t   [4] = '{9, 0, 0, 9};
    int   x_t   [4] = '{1, 0, 0, 1};
    int   e_t   [4] = '{0, 1, 0, 0};
    int   v_t   [4] = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ld_t[i], 4'd12, en_t[i], 1'b1, 1'b0, clr_t[i]);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL load_clamp dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (int'(o_cnt[2]) != c_t[i] || int'(o_max[2]) != x_t[i] ||
          int'(o_evt[2]) != e_t[i] || int'(o_ovf[2]) != v_t[i]) begin
        n_err++;
        $display("FAIL load_clamp_const dut2 step%0d: got cnt=%0d max=%0d evt=%0d ovf=%0d required %0d %0d %0d %0d",
                 i, o_cnt[2], o_max[2], o_evt[2], o_ovf[2], c_t[i], x_t[i], e_t[i], v_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rst_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic ld_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic en_t  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] lv_t [4] = '{4'd6, 4'd0, 4'd3, 4'd0};
    int   c_t   [4] = '{6, 7, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(rst_t[i], ld_t[i], lv_t[i], en_t[i], 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset_mid dut%0d step%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (int'(o_cnt[0]) != c_t[i]) begin
        n_err++;
        $display("FAIL reset_mid_const dut0 step%0d: got %0d required %0d", i, o_cnt[0], c_t[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d: got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_both_dirs();
    test_load_clamp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
